// File: rtl/rv32_lsu_pkg.sv
// ============================================================================
// Module : rv32_lsu_pkg
// Brief  : Shared funct3 codes, FSM encoding and decode helpers for the LSU.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package rv32_lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;
  localparam logic [1:0] ST_RESP = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_REQ  = ST_REQ,
    S_WAIT = ST_WAIT,
    S_RESP = ST_RESP
  } state_e;

  // Returns {sig, b_hbar, bypass} for the load extender.
  function automatic logic [2:0] ext_ctrl(input logic [2:0] f3);
    case (f3)
      F3_B:    ext_ctrl = 3'b110;
      F3_H:    ext_ctrl = 3'b100;
      F3_W:    ext_ctrl = 3'b001;
      F3_BU:   ext_ctrl = 3'b010;
      F3_HU:   ext_ctrl = 3'b000;
      default: ext_ctrl = 3'b000;
    endcase
  endfunction

  function automatic logic is_illegal(input logic we, input logic [2:0] f3);
    if (we) is_illegal = (f3 > F3_W);
    else    is_illegal = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
  endfunction

  // Size lives in funct3[1:0]; callers rule out illegal codes first.
  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] off);
    case (f3[1:0])
      2'b01:   is_misaligned = off[0];
      2'b10:   is_misaligned = (off != 2'b00);
      default: is_misaligned = 1'b0;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/lsu_store_fmt.sv
// ============================================================================
// Module : lsu_store_fmt
// Brief  : Replicates store data across the word and builds byte strobes.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module lsu_store_fmt
  import rv32_lsu_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] wdata_o,
  output logic [3:0]  wstrb_o
);

  always_comb begin
    wdata_o = wdata_i;
    wstrb_o = 4'b1111;
    case (funct3_i)
      F3_B: begin
        wdata_o = {4{wdata_i[7:0]}};
        wstrb_o = 4'b0001 << off_i;
      end
      F3_H: begin
        wdata_o = {2{wdata_i[15:0]}};
        wstrb_o = off_i[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        wdata_o = wdata_i;
        wstrb_o = 4'b1111;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/lsu_ctrl.sv
// ============================================================================
// Module : lsu_ctrl
// Brief  : RV32 load/store sequencer between execute stage and data memory.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module lsu_ctrl
  import rv32_lsu_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_we_i,
  input  logic [2:0]        req_funct3_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [31:0]       req_wdata_i,
  output logic              resp_valid_o,
  output logic [31:0]       resp_rdata_o,
  output logic              resp_misaligned_o,
  output logic              resp_illegal_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [31:0]       mem_wdata_o,
  output logic [3:0]        mem_wstrb_o,
  input  logic              mem_gnt_i,
  input  logic              mem_rvalid_i,
  input  logic [31:0]       mem_rdata_i,
  output logic [31:0]       ext_data_in_o,
  output logic              ext_sig_o,
  output logic              ext_b_hbar_o,
  output logic              ext_bypass_o,
  input  logic [31:0]       ext_data_out_i
);

  state_e state_q, state_d;

  logic              we_q, illegal_q, misaligned_q;
  logic [1:0]        off_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [31:0]       mem_wdata_q;
  logic [3:0]        mem_wstrb_q;
  logic [31:0]       ext_data_q;
  logic [2:0]        ext_ctrl_q;

  logic        accept_w, illegal_w, misaligned_w, fault_w, store_w;
  logic [31:0] fmt_wdata_w;
  logic [3:0]  fmt_wstrb_w;

  assign accept_w     = (state_q == S_IDLE) && req_valid_i;
  assign illegal_w    = is_illegal(req_we_i, req_funct3_i);
  assign misaligned_w = !illegal_w && is_misaligned(req_funct3_i, req_addr_i[1:0]);
  assign fault_w      = illegal_w || misaligned_w;
  assign store_w      = req_we_i && !fault_w;

  lsu_store_fmt u_store_fmt (
    .funct3_i (req_funct3_i),
    .off_i    (req_addr_i[1:0]),
    .wdata_i  (req_wdata_i),
    .wdata_o  (fmt_wdata_w),
    .wstrb_o  (fmt_wstrb_w)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (req_valid_i) state_d = fault_w ? S_RESP : S_REQ;
      S_REQ:  if (mem_gnt_i)   state_d = we_q ? S_RESP : S_WAIT;
      S_WAIT: if (mem_rvalid_i) state_d = S_RESP;
      S_RESP: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      we_q         <= 1'b0;
      illegal_q    <= 1'b0;
      misaligned_q <= 1'b0;
      off_q        <= 2'b00;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_wstrb_q  <= '0;
      ext_data_q   <= '0;
      ext_ctrl_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept_w) begin
        we_q         <= req_we_i;
        illegal_q    <= illegal_w;
        misaligned_q <= misaligned_w;
        off_q        <= req_addr_i[1:0];
        mem_we_q     <= store_w;
        mem_addr_q   <= {req_addr_i[ADDR_W-1:2], 2'b00};
        mem_wdata_q  <= store_w ? fmt_wdata_w : 32'h0;
        mem_wstrb_q  <= store_w ? fmt_wstrb_w : 4'h0;
        ext_ctrl_q   <= (req_we_i || fault_w) ? 3'b000 : ext_ctrl(req_funct3_i);
      end
      // Shift the addressed byte/half down to bit 0 for the extender.
      if (state_q == S_WAIT && mem_rvalid_i)
        ext_data_q <= mem_rdata_i >> {off_q, 3'b000};
    end
  end

  assign req_ready_o       = (state_q == S_IDLE);
  assign resp_valid_o      = (state_q == S_RESP);
  assign resp_illegal_o    = resp_valid_o && illegal_q;
  assign resp_misaligned_o = resp_valid_o && misaligned_q;
  assign resp_rdata_o      = (resp_valid_o && !we_q && !illegal_q && !misaligned_q)
                             ? ext_data_out_i : 32'h0;

  assign mem_req_o   = (state_q == S_REQ);
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign mem_wstrb_o = mem_wstrb_q;

  assign ext_data_in_o = ext_data_q;
  assign ext_sig_o     = ext_ctrl_q[2];
  assign ext_b_hbar_o  = ext_ctrl_q[1];
  assign ext_bypass_o  = ext_ctrl_q[0];

endmodule

`default_nettype wire

// File: tb/tb_lsu_ctrl.sv
// ============================================================================
// Module : tb_lsu_ctrl
// Brief  : Directed plus randomized self-checking bench for lsu_ctrl.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_lsu_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_misaligned, resp_illegal;
  logic [31:0] resp_rdata;
  logic        mem_req, mem_we, mem_gnt, mem_rvalid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] ext_data_in, ext_data_out;
  logic        ext_sig, ext_b_hbar, ext_bypass;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  lsu_ctrl #(.ADDR_W(32)) dut (
    .clk               (clk),
    .rst               (rst),
    .req_valid_i       (req_valid),
    .req_ready_o       (req_ready),
    .req_we_i          (req_we),
    .req_funct3_i      (req_funct3),
    .req_addr_i        (req_addr),
    .req_wdata_i       (req_wdata),
    .resp_valid_o      (resp_valid),
    .resp_rdata_o      (resp_rdata),
    .resp_misaligned_o (resp_misaligned),
    .resp_illegal_o    (resp_illegal),
    .mem_req_o         (mem_req),
    .mem_we_o          (mem_we),
    .mem_addr_o        (mem_addr),
    .mem_wdata_o       (mem_wdata),
    .mem_wstrb_o       (mem_wstrb),
    .mem_gnt_i         (mem_gnt),
    .mem_rvalid_i      (mem_rvalid),
    .mem_rdata_i       (mem_rdata),
    .ext_data_in_o     (ext_data_in),
    .ext_sig_o         (ext_sig),
    .ext_b_hbar_o      (ext_b_hbar),
    .ext_bypass_o      (ext_bypass),
    .ext_data_out_i    (ext_data_out)
  );

  // Stand-in for the external load extender that sits beside the controller.
  always_comb begin
    ext_data_out = ext_data_in;
    if (!ext_bypass) begin
      if (ext_b_hbar) ext_data_out = {{24{ext_sig & ext_data_in[7]}}, ext_data_in[7:0]};
      else            ext_data_out = {{16{ext_sig & ext_data_in[15]}}, ext_data_in[15:0]};
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: plain arithmetic on the architectural rules.
  function automatic bit m_illegal(bit we, int f3);
    if (we) return f3 >= 3;
    return (f3 == 3) || (f3 == 6) || (f3 == 7);
  endfunction

  function automatic bit m_misal(int f3, int off);
    int sz = f3 % 4;
    return (sz == 1 && (off % 2) != 0) || (sz == 2 && off != 0);
  endfunction

  function automatic logic [31:0] m_load(int f3, logic [31:0] word, int off);
    logic [31:0] s, v;
    s = word >> (8 * off);
    v = s;
    if (f3 == 0 || f3 == 4) begin
      v = s & 32'hFF;
      if (f3 == 0 && v >= 128) v = v - 32'd256;
    end else if (f3 == 1 || f3 == 5) begin
      v = s & 32'hFFFF;
      if (f3 == 1 && v >= 32768) v = v - 32'd65536;
    end
    return v;
  endfunction

  function automatic logic [31:0] m_ext(bit we, int f3, bit fault);
    if (we || fault) return 0;
    return {29'd0, f3 < 2, (f3 == 0 || f3 == 4), f3 == 2};
  endfunction

  task automatic do_txn(input bit we, input int f3, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [31:0] rd,
                        input int gd, input int rvd);
    int off;
    bit ill, mis;
    logic [31:0] e_wdata, e_ctrl;
    logic [3:0]  e_wstrb;
    off = int'(addr % 4);
    ill = m_illegal(we, f3);
    mis = !ill && m_misal(f3, off);
    e_ctrl = m_ext(we, f3, ill || mis);
    e_wdata = 0;
    e_wstrb = 0;
    if (we) begin
      if (f3 == 0)      begin e_wdata = (wd & 32'hFF) * 32'h0101_0101;   e_wstrb = 4'(1 << off); end
      else if (f3 == 1) begin e_wdata = (wd & 32'hFFFF) * 32'h0001_0001; e_wstrb = 4'(3 << ((off / 2) * 2)); end
      else              begin e_wdata = wd;                              e_wstrb = 4'hF; end
    end

    check("ready_idle", {31'd0, req_ready}, 1);
    req_valid = 1; req_we = we; req_funct3 = 3'(f3); req_addr = addr; req_wdata = wd;
    tick();
    req_valid = 0; req_we = 1'($urandom); req_funct3 = 3'($urandom);
    req_addr = $urandom; req_wdata = $urandom;

    if (ill || mis) begin
      check("fault_valid", {31'd0, resp_valid}, 1);
      check("fault_ill", {31'd0, resp_illegal}, {31'd0, ill});
      check("fault_mis", {31'd0, resp_misaligned}, {31'd0, mis});
      check("fault_rdata", resp_rdata, 0);
      check("fault_memreq", {31'd0, mem_req}, 0);
      check("fault_ext", {29'd0, ext_sig, ext_b_hbar, ext_bypass}, 0);
      tick();
      check("fault_memreq2", {31'd0, mem_req}, 0);
    end else begin
      for (int i = 0; i <= gd; i++) begin
        check("req_memreq", {31'd0, mem_req}, 1);
        check("req_ready0", {31'd0, req_ready}, 0);
        check("req_addr", mem_addr, addr & 32'hFFFF_FFFC);
        check("req_we", {31'd0, mem_we}, {31'd0, we});
        check("req_wstrb", {28'd0, mem_wstrb}, {28'd0, e_wstrb});
        if (we) check("req_wdata", mem_wdata, e_wdata);
        check("req_respv", {31'd0, resp_valid}, 0);
        mem_gnt = (i == gd);
        tick();
      end
      mem_gnt = 0;
      if (we) begin
        check("st_valid", {31'd0, resp_valid}, 1);
        check("st_rdata", resp_rdata, 0);
        check("st_flags", {30'd0, resp_illegal, resp_misaligned}, 0);
        check("st_memreq", {31'd0, mem_req}, 0);
      end else begin
        check("wait_memreq", {31'd0, mem_req}, 0);
        check("wait_rdata", resp_rdata, 0);
        for (int i = 0; i < rvd; i++) begin
          mem_rdata = $urandom;
          tick();
          check("wait_respv", {31'd0, resp_valid}, 0);
        end
        mem_rvalid = 1; mem_rdata = rd;
        tick();
        mem_rvalid = 0; mem_rdata = $urandom;
        check("ld_valid", {31'd0, resp_valid}, 1);
        check("ld_extin", ext_data_in, rd >> (8 * off));
        check("ld_ext", {29'd0, ext_sig, ext_b_hbar, ext_bypass}, e_ctrl);
        check("ld_rdata", resp_rdata, m_load(f3, rd, off));
        check("ld_flags", {30'd0, resp_illegal, resp_misaligned}, 0);
      end
    end
    tick();
    check("post_respv", {31'd0, resp_valid}, 0);
    check("post_rdata", resp_rdata, 0);
    check("post_ready", {31'd0, req_ready}, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    rst = 1; req_valid = 0; req_we = 0; req_funct3 = 0; req_addr = 0; req_wdata = 0;
    mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0;
    tick(); tick();
    check("rst_ready", {31'd0, req_ready}, 1);
    check("rst_memreq", {31'd0, mem_req}, 0);
    check("rst_respv", {31'd0, resp_valid}, 0);
    check("rst_rdata", resp_rdata, 0);
    check("rst_wstrb", {28'd0, mem_wstrb}, 0);
    check("rst_ext", {29'd0, ext_sig, ext_b_hbar, ext_bypass}, 0);
    check("rst_extin", ext_data_in, 0);
    rst = 0;
    tick();

    do_txn(0, 0, 32'h1003, 0, 32'h80FF_1234, 0, 0);
    do_txn(0, 4, 32'h1003, 0, 32'h80FF_1234, 0, 0);
    do_txn(0, 1, 32'h2002, 0, 32'h8001_7FFF, 0, 0);
    do_txn(0, 1, 32'h2001, 0, 32'h8001_7FFF, 0, 0);
    do_txn(1, 0, 32'h3002, 32'h1234_56AB, 0, 0, 0);
    do_txn(1, 1, 32'h3002, 32'h1234_56AB, 0, 0, 0);
    do_txn(1, 2, 32'h3004, 32'hDEAD_BEEF, 0, 5, 0);
    do_txn(0, 3, 32'h4000, 0, 0, 0, 0);
    do_txn(1, 3, 32'h4001, 32'h5555_AAAA, 0, 0, 0);

    // Reset mid-load while waiting for read data.
    req_valid = 1; req_we = 0; req_funct3 = 3'd2; req_addr = 32'h5000;
    tick();
    req_valid = 0;
    mem_gnt = 1;
    tick();
    mem_gnt = 0;
    #2 rst = 1;
    #1;
    check("arst_memreq", {31'd0, mem_req}, 0);
    check("arst_respv", {31'd0, resp_valid}, 0);
    check("arst_ready", {31'd0, req_ready}, 1);
    tick();
    rst = 0;
    mem_rvalid = 1; mem_rdata = 32'hCAFE_F00D;
    tick();
    mem_rvalid = 0;
    for (int i = 0; i < 3; i++) begin
      check("late_rvalid", {31'd0, resp_valid}, 0);
      tick();
    end
    do_txn(0, 2, 32'h5008, 0, 32'h1357_9BDF, 1, 2);

    for (int n = 0; n < 60; n++) begin
      bit we;
      int f3;
      logic [31:0] a;
      we = 1'($urandom);
      f3 = int'($urandom % 8);
      a  = $urandom;
      if ($urandom % 2 == 0) a = a & 32'hFFFF_FFFC;
      do_txn(we, f3, a, $urandom, $urandom, int'($urandom % 4), int'($urandom % 3));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
